// File: rtl/tx_am_scheduler_if.sv
// Control/status bundle between MAC-side sequencing control and the 40G PCS TX AM scheduler.
// Latency: wires only; all timing lives in the scheduler.
// Backpressure: none on this bundle; src_ready paces the encoder source.
interface tx_am_scheduler_if;
    logic       tx_en;
    logic       test_mode_req;
    logic       src_ready;
    logic       am_insert;
    logic [1:0] am_lane;
    logic       scram_rst;
    logic       tx_test_mode;
    logic [2:0] state_o;

    // Controller side: drives the requests, observes the scheduler outputs.
    modport master (
        output tx_en, test_mode_req,
        input  src_ready, am_insert, am_lane, scram_rst, tx_test_mode, state_o
    );

    // Scheduler side.
    modport slave (
        input  tx_en, test_mode_req,
        output src_ready, am_insert, am_lane, scram_rst, tx_test_mode, state_o
    );
endinterface

// File: rtl/tx_am_scheduler.sv
// Sequences scrambler-reset start-up, encoder pacing and per-lane AM groups for the 40G PCS TX path.
// Latency: outputs decode registered state/counters, so they change one TX_CLK after the deciding input.
// Backpressure: src_ready is low during start-up and AM slots; the encoder must hold its block then.
module tx_am_scheduler #(
    parameter int NUM_LANES      = 4,
    parameter int AM_PERIOD      = 16383,
    parameter int SCR_RST_CYCLES = 8
) (
    input logic              TX_CLK,
    input logic              reset,
    tx_am_scheduler_if.slave ctl
);

    // Terminal counts; blk_cnt is sized so its terminal value is never exceeded.
    localparam int BLK_W = $clog2(AM_PERIOD * NUM_LANES);
    localparam int RST_W = $clog2(SCR_RST_CYCLES + 1);

    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(AM_PERIOD * NUM_LANES - 1);
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(SCR_RST_CYCLES - 1);
    localparam logic [1:0]       LANE_LAST = 2'(NUM_LANES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCR_INIT = 3'd1,
        ST_AM       = 3'd2,
        ST_DATA     = 3'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RST_W-1:0]  rst_cnt;
    logic [1:0]        lane_cnt;
    logic [BLK_W-1:0]  blk_cnt;
    logic              test_mode_q;

    logic              scram_rst;
    logic              src_ready;
    logic              am_insert;
    logic [1:0]        am_lane;

    // State register; reset drops straight to IDLE, truncating any AM group in flight.
    always_ff @(posedge TX_CLK or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters and test-mode latch; test mode only changes on the last lane of an AM group.
    always_ff @(posedge TX_CLK or negedge reset) begin
        if (!reset) begin
            rst_cnt     <= '0;
            lane_cnt    <= '0;
            blk_cnt     <= '0;
            test_mode_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rst_cnt  <= '0;
                    lane_cnt <= '0;
                    blk_cnt  <= '0;
                end
                ST_SCR_INIT: begin
                    rst_cnt <= rst_cnt + 1'b1;
                end
                ST_AM: begin
                    if (lane_cnt == LANE_LAST) begin
                        lane_cnt    <= '0;
                        blk_cnt     <= '0;
                        test_mode_q <= ctl.test_mode_req;
                    end else begin
                        lane_cnt <= lane_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    // Terminal count hands over to AM, which clears the counter.
                    if (blk_cnt != BLK_LAST) begin
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                end
                default: begin
                    rst_cnt  <= '0;
                    lane_cnt <= '0;
                    blk_cnt  <= '0;
                end
            endcase
        end
    end

    // Next-state: an AM group, once started, always runs all lanes; tx_en only acts at its end.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ctl.tx_en) begin
                    state_nxt = ST_SCR_INIT;
                end
            end
            ST_SCR_INIT: begin
                if (!ctl.tx_en) begin
                    state_nxt = ST_IDLE;
                end else if (rst_cnt == RST_LAST) begin
                    state_nxt = ST_AM;
                end
            end
            ST_AM: begin
                if (lane_cnt == LANE_LAST) begin
                    state_nxt = ctl.tx_en ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (blk_cnt == BLK_LAST) begin
                    state_nxt = ST_AM;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: exactly one of scram_rst/src_ready/am_insert is high in any active state.
    always_comb begin
        scram_rst = 1'b0;
        src_ready = 1'b0;
        am_insert = 1'b0;
        am_lane   = 2'd0;
        case (state)
            ST_IDLE:     scram_rst = 1'b1;
            ST_SCR_INIT: scram_rst = 1'b1;
            ST_AM: begin
                am_insert = 1'b1;
                am_lane   = lane_cnt;
            end
            ST_DATA:     src_ready = 1'b1;
            default:     scram_rst = 1'b1;
        endcase
    end

    assign ctl.scram_rst    = scram_rst;
    assign ctl.src_ready    = src_ready;
    assign ctl.am_insert    = am_insert;
    assign ctl.am_lane      = am_lane;
    assign ctl.tx_test_mode = test_mode_q;
    assign ctl.state_o      = state;

endmodule

// File: tb/tb_tx_am_scheduler.sv
// Directed bench for tx_am_scheduler: small instance (AM_PERIOD=4, SCR_RST_CYCLES=3) plus a default instance.
// Inputs are driven and outputs sampled on the falling edge of TX_CLK.
// Summary line reports total checks and errors.
module tb_tx_am_scheduler;

    logic TX_CLK = 1'b0;
    logic reset;
    logic reset_def;
    int   checks = 0;
    int   errors = 0;
    logic def_done = 1'b0;

    always #5 TX_CLK = ~TX_CLK;

    tx_am_scheduler_if ifc ();
    tx_am_scheduler_if ifd ();

    tx_am_scheduler #(
        .NUM_LANES      (4),
        .AM_PERIOD      (4),
        .SCR_RST_CYCLES (3)
    ) dut (
        .TX_CLK (TX_CLK),
        .reset  (reset),
        .ctl    (ifc)
    );

    tx_am_scheduler dut_def (
        .TX_CLK (TX_CLK),
        .reset  (reset_def),
        .ctl    (ifd)
    );

    // {state, scram_rst, src_ready, am_insert, am_lane, tx_test_mode}
    wire [8:0] obs = {ifc.state_o, ifc.scram_rst, ifc.src_ready, ifc.am_insert,
                      ifc.am_lane, ifc.tx_test_mode};

    localparam logic [8:0] RST_VAL = 9'b000_1_0_0_00_0;

    function automatic logic [8:0] pack(input int st, input bit scr, input bit src,
                                        input bit am, input int lane, input bit tm);
        pack = {3'(st), scr, src, am, 2'(lane), tm};
    endfunction

    // Expected outputs c cycles after reset release with tx_en held high:
    // c0 IDLE, c1..3 SCR_INIT, then period 20 = 4 AM lanes + 16 DATA.
    function automatic logic [8:0] expect_run(input int c, input bit tm);
        int p;
        if (c == 0)      expect_run = pack(0, 1, 0, 0, 0, tm);
        else if (c <= 3) expect_run = pack(1, 1, 0, 0, 0, tm);
        else begin
            p = (c - 4) % 20;
            if (p < 4) expect_run = pack(2, 0, 0, 1, p, tm);
            else       expect_run = pack(3, 0, 1, 0, 0, tm);
        end
    endfunction

    task automatic reset_and_start();
        reset = 1'b0;
        ifc.tx_en = 1'b0;
        ifc.test_mode_req = 1'b0;
        @(negedge TX_CLK);
        reset = 1'b1;
        ifc.tx_en = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifc.tx_en = 1'b0;
        ifc.test_mode_req = 1'b0;
        @(negedge TX_CLK);
        checks++;
        if (obs !== RST_VAL) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs, RST_VAL);
        end
        ifc.tx_en = 1'b1;
        ifc.test_mode_req = 1'b1;
        @(negedge TX_CLK);
        checks++;
        if (obs !== RST_VAL) begin
            errors++;
            $display("FAIL reset_dominates got=%b exp=%b", obs, RST_VAL);
        end
    endtask

    task automatic test_startup();
        reset_and_start();
        for (int c = 0; c <= 47; c++) begin
            if (c > 0) @(negedge TX_CLK);
            checks++;
            if (obs !== expect_run(c, 1'b0)) begin
                errors++;
                $display("FAIL startup c=%0d got=%b exp=%b", c, obs, expect_run(c, 1'b0));
            end
        end
    endtask

    task automatic test_test_mode();
        bit tm;
        reset_and_start();
        for (int c = 1; c <= 50; c++) begin
            @(negedge TX_CLK);
            tm = (c >= 28 && c <= 47);
            checks++;
            if (obs !== expect_run(c, tm)) begin
                errors++;
                $display("FAIL test_mode c=%0d got=%b exp=%b", c, obs, expect_run(c, tm));
            end
            if (c == 13) ifc.test_mode_req = 1'b1;
            if (c == 35) ifc.test_mode_req = 1'b0;
        end
    endtask

    task automatic test_tx_disable();
        logic [8:0] e;
        reset_and_start();
        for (int c = 1; c <= 31; c++) begin
            @(negedge TX_CLK);
            if (c <= 27) e = expect_run(c, 1'b0);
            else         e = pack(0, 1, 0, 0, 0, 0);
            if (c >= 10) begin
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL tx_disable c=%0d got=%b exp=%b", c, obs, e);
                end
            end
            if (c == 10) ifc.tx_en = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        reset_and_start();
        ifc.test_mode_req = 1'b1;
        repeat (25) @(negedge TX_CLK);
        checks++;
        if (obs !== expect_run(25, 1'b1)) begin
            errors++;
            $display("FAIL reset_mid_pre got=%b exp=%b", obs, expect_run(25, 1'b1));
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== RST_VAL) begin
            errors++;
            $display("FAIL reset_mid_async got=%b exp=%b", obs, RST_VAL);
        end
        @(negedge TX_CLK);
        reset = 1'b1;
        ifc.tx_en = 1'b1;
        ifc.test_mode_req = 1'b0;
        for (int c = 0; c <= 27; c++) begin
            if (c > 0) @(negedge TX_CLK);
            checks++;
            if (obs !== expect_run(c, 1'b0)) begin
                errors++;
                $display("FAIL reset_mid_restart c=%0d got=%b exp=%b", c, obs, expect_run(c, 1'b0));
            end
        end
    endtask

    task automatic test_scr_abort();
        logic [8:0] e;
        reset_and_start();
        for (int c = 1; c <= 12; c++) begin
            @(negedge TX_CLK);
            e = (c <= 2) ? expect_run(c, 1'b0) : expect_run(c - 3, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL scr_abort c=%0d got=%b exp=%b", c, obs, e);
            end
            if (c == 2) ifc.tx_en = 1'b0;
            if (c == 3) ifc.tx_en = 1'b1;
        end
    endtask

    // Exclusivity of the three phase outputs on the small instance, every cycle out of reset.
    always @(negedge TX_CLK) begin
        if (reset === 1'b1) begin
            checks++;
            if ((ifc.src_ready && ifc.am_insert) ||
                (ifc.state_o != 3'd0 &&
                 (int'(ifc.scram_rst) + int'(ifc.src_ready) + int'(ifc.am_insert)) != 1)) begin
                errors++;
                $display("FAIL exclusive st=%0d scr=%b src=%b am=%b",
                         ifc.state_o, ifc.scram_rst, ifc.src_ready, ifc.am_insert);
            end
        end
    end

    // Default-parameter instance: 65532 data cycles between full 4-lane AM groups.
    initial begin : def_run
        int cnt;
        reset_def = 1'b0;
        ifd.tx_en = 1'b0;
        ifd.test_mode_req = 1'b0;
        @(negedge TX_CLK);
        @(negedge TX_CLK);
        reset_def = 1'b1;
        ifd.tx_en = 1'b1;
        cnt = 0;
        while (ifd.am_insert !== 1'b1 && cnt < 100) begin
            @(negedge TX_CLK);
            cnt++;
        end
        checks++;
        if (ifd.am_insert !== 1'b1) begin
            errors++;
            $display("FAIL def_first_am got=%b exp=1", ifd.am_insert);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ifd.am_insert !== 1'b1 || ifd.am_lane !== 2'(i)) begin
                errors++;
                $display("FAIL def_am1 lane%0d got am=%b lane=%0d", i, ifd.am_insert, ifd.am_lane);
            end
            @(negedge TX_CLK);
        end
        cnt = 0;
        while (ifd.src_ready === 1'b1 && cnt < 70000) begin
            @(negedge TX_CLK);
            cnt++;
        end
        checks++;
        if (cnt !== 65532) begin
            errors++;
            $display("FAIL def_data_len got=%0d exp=65532", cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ifd.am_insert !== 1'b1 || ifd.am_lane !== 2'(i)) begin
                errors++;
                $display("FAIL def_am2 lane%0d got am=%b lane=%0d", i, ifd.am_insert, ifd.am_lane);
            end
            @(negedge TX_CLK);
        end
        checks++;
        if (ifd.src_ready !== 1'b1) begin
            errors++;
            $display("FAIL def_data_resume got=%b exp=1", ifd.src_ready);
        end
        def_done = 1'b1;
    end

    initial begin
        reset = 1'b0;
        ifc.tx_en = 1'b0;
        ifc.test_mode_req = 1'b0;
        test_reset();
        test_startup();
        test_test_mode();
        test_tx_disable();
        test_reset_mid();
        test_scr_abort();
        for (int i = 0; i < 70000 && !def_done; i++) @(negedge TX_CLK);
        checks++;
        if (!def_done) begin
            errors++;
            $display("FAIL def_timeout got=0 exp=1");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
